// File: rtl/ifq_pkg.sv
// Shared widths and entry layout for the instruction-fetch prefetch queue.
package ifq_pkg;
    localparam int IFQ_ADDR_W  = 8;
    localparam int IFQ_INST_W  = 16;
    localparam int IFQ_DEPTH   = 4;
    localparam int IFQ_PTR_W   = $clog2(IFQ_DEPTH);
    localparam int IFQ_ENTRY_W = IFQ_INST_W + IFQ_ADDR_W;

    // Queue entry: instruction in the MSBs, next PC below it.
    typedef struct packed {
        logic [IFQ_INST_W-1:0] inst;
        logic [IFQ_ADDR_W-1:0] new_pc;
    } ifq_entry_t;
endpackage

// File: rtl/ifq_fifo.sv
// Circular entry store for the fetch queue: storage, wrapping pointers, occupancy count.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int W     = IFQ_ENTRY_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rptr, wptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
        end
    end
endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: PC/issue credit, one-deep in-flight tracking, branch redirect, prefetch queue.
// IFQ_BYPASS_EN: forward an arriving response straight to the head when the queue is empty.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int ADDR_W = IFQ_ADDR_W,
    parameter int INST_W = IFQ_INST_W,
    parameter int DEPTH  = IFQ_DEPTH
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              iBrTaken,
    input  logic [ADDR_W-1:0] iBrDir,
    output logic              oImemReq,
    output logic [ADDR_W-1:0] oImemAddr,
    input  logic [INST_W-1:0] iImemData,
    output logic              oValid,
    output logic [INST_W-1:0] oInst,
    output logic [ADDR_W-1:0] oNewPc,
    input  logic              iReady
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = INST_W + ADDR_W;

    logic [ADDR_W-1:0] pc, tag;
    logic              inflight;
    logic [PW:0]       count;
    logic [PW+1:0]     credit;
    logic              empty, full;
    logic [EW-1:0]     din, dout;
    logic              issue, resp, push, pop;

    // Credit ignores a same-cycle pop so issue never depends on iReady.
    assign credit = {1'b0, count} + (PW+2)'(inflight);
    assign issue  = !clr && !iBrTaken && !full && (credit < (PW+2)'(DEPTH));
    assign resp   = inflight && !iBrTaken;
    assign din    = {iImemData, tag + ADDR_W'(1)};

    assign oImemReq  = issue;
    assign oImemAddr = pc;

`ifdef IFQ_BYPASS_EN
    logic byp;
    assign byp    = empty && resp;
    assign push   = resp && !(empty && iReady);
    assign pop    = !empty && iReady && !iBrTaken;
    assign oValid = !empty || byp;
    assign {oInst, oNewPc} = !empty ? dout : (byp ? din : '0);
`else
    assign push   = resp;
    assign pop    = !empty && iReady && !iBrTaken;
    assign oValid = !empty;
    assign {oInst, oNewPc} = dout;
`endif

    ifq_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .flush (iBrTaken),
        .din   (din),
        .dout  (dout),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc       <= '0;
            tag      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (iBrTaken) begin
                pc <= iBrDir;
            end else if (issue) begin
                pc  <= pc + ADDR_W'(1);
                tag <= pc;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a queue-level reference model (IFQ_BYPASS_EN aware).
module tb_ifetch_queue;
    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        iBrTaken;
    logic [7:0]  iBrDir;
    logic        oImemReq;
    logic [7:0]  oImemAddr;
    logic [15:0] iImemData = '0;
    logic        oValid;
    logic [15:0] oInst;
    logic [7:0]  oNewPc;
    logic        iReady;

    int n_chk  = 0;
    int n_pass = 0;

    ifetch_queue dut (
        .clk       (clk),
        .clr       (clr),
        .iBrTaken  (iBrTaken),
        .iBrDir    (iBrDir),
        .oImemReq  (oImemReq),
        .oImemAddr (oImemAddr),
        .iImemData (iImemData),
        .oValid    (oValid),
        .oInst     (oInst),
        .oNewPc    (oNewPc),
        .iReady    (iReady)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [7:0] a);
        return {a ^ 8'h5A, ~a};
    endfunction

    // Instruction memory: fixed one-cycle read latency.
    always @(posedge clk) iImemData <= mem_fn(oImemAddr);

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", nm, got, exp);
    endtask

    // Reference model: queue of fetch addresses plus one in-flight tag.
    logic [7:0] mq[$];
    logic [7:0] m_pc   = '0;
    logic [7:0] m_tag  = '0;
    bit         m_infl = 1'b0;

    initial forever begin
        @(posedge clk or posedge clr);
        if (clr) begin
            mq.delete();
            m_pc = '0; m_tag = '0; m_infl = 1'b0;
        end else begin
            int  sz;
            bit  iss;
            sz  = mq.size();
            iss = (sz + int'(m_infl) < DEPTH) && !iBrTaken;
            if (iBrTaken) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = iBrDir;
            end else begin
`ifdef IFQ_BYPASS_EN
                if (sz == 0 && m_infl) begin
                    if (!iReady) mq.push_back(m_tag);
                end else begin
                    if (sz > 0 && iReady) void'(mq.pop_front());
                    if (m_infl) mq.push_back(m_tag);
                end
`else
                if (sz > 0 && iReady) void'(mq.pop_front());
                if (m_infl) mq.push_back(m_tag);
`endif
                m_infl = iss;
                if (iss) begin
                    m_tag = m_pc;
                    m_pc  = m_pc + 8'd1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        begin
            bit         ev, er;
            logic [7:0] hd;
            ev = mq.size() > 0;
            hd = ev ? mq[0] : 8'd0;
`ifdef IFQ_BYPASS_EN
            if (!ev && m_infl && !iBrTaken) begin ev = 1'b1; hd = m_tag; end
`endif
            er = !clr && (mq.size() + int'(m_infl) < DEPTH) && !iBrTaken;
            chk("cycle", {30'd0, oImemReq, oImemAddr, oValid, oInst, oNewPc},
                {30'd0, er, m_pc, ev, ev ? mem_fn(hd) : 16'd0, ev ? 8'(hd + 8'd1) : 8'd0});
        end
    end

    task automatic go(input bit br, input logic [7:0] dir, input bit rdy);
        @(posedge clk); #1;
        iBrTaken = br; iBrDir = dir; iReady = rdy;
        @(negedge clk);
    endtask

    task automatic rel(input bit rdy);
        @(posedge clk); #1;
        clr = 1'b0; iBrTaken = 1'b0; iReady = rdy;
        @(negedge clk);
    endtask

    task automatic pulse_clr(input string nm);
        @(posedge clk); #1;
        clr = 1'b1; iBrTaken = 1'b0; iReady = 1'b0;
        #1;
        chk(nm, {oImemReq, oImemAddr, oValid, oInst, oNewPc}, '0);
        @(negedge clk);
    endtask

    task automatic chk_head(input string nm, input logic [7:0] npc);
        chk({nm, "_valid"}, oValid, 1'b1);
        chk({nm, "_npc"}, oNewPc, npc);
        chk({nm, "_inst"}, oInst, mem_fn(8'(npc - 8'd1)));
    endtask

    initial begin
        clr = 1'b1; iBrTaken = 1'b0; iBrDir = '0; iReady = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", {oImemReq, oImemAddr, oValid, oInst, oNewPc}, '0);

        // Streaming with iReady held high
        rel(1'b1);
        chk("c0_req", {oImemReq, oImemAddr}, {1'b1, 8'h00});
        chk("c0_valid", oValid, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            go(1'b0, 8'h00, 1'b1);
            if (k < LAT) chk("stream_lat", oValid, 1'b0);
            else chk_head("stream", 8'(k - LAT + 1));
        end

        // Reset during an in-flight fetch
        pulse_clr("clr_async");
        rel(1'b1);
        for (int k = 1; k <= LAT; k++) begin
            go(1'b0, 8'h00, 1'b1);
            if (k < LAT) chk("reclr_lat", oValid, 1'b0);
            else chk_head("reclr_first", 8'h01);
        end

        // Back-pressure: fill then drain
        pulse_clr("clr_bp");
        rel(1'b0);
        for (int k = 1; k <= 9; k++) begin
            go(1'b0, 8'h00, 1'b0);
            if (k >= 4) chk("bp_req_off", oImemReq, 1'b0);
        end
        chk_head("bp_hold", 8'h01);
        for (int j = 0; j < 5; j++) begin
            go(1'b0, 8'h00, 1'b1);
            chk_head("bp_drain", 8'(j + 1));
        end

        // Branch with 3 queued and 1 in flight
        pulse_clr("clr_br");
        rel(1'b0);
        repeat (3) go(1'b0, 8'h00, 1'b0);
        go(1'b1, 8'h40, 1'b0);
        chk("br_noreq", oImemReq, 1'b0);
        go(1'b0, 8'h00, 1'b1);
        chk("br_req", {oImemReq, oImemAddr}, {1'b1, 8'h40});
        chk("br_gap0", oValid, 1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            go(1'b0, 8'h00, 1'b1);
            if (k < LAT) chk("br_gap", oValid, 1'b0);
            else chk_head("br_tgt", 8'(8'h41 + 8'(k - LAT)));
        end

        // Address wrap
        go(1'b1, 8'hFE, 1'b1);
        for (int k = 1; k <= LAT + 3; k++) begin
            go(1'b0, 8'h00, 1'b1);
            if (k <= LAT) chk("wrap_gap", oValid, 1'b0);
            else chk_head("wrap", 8'(8'hFE + 8'(k - LAT)));
        end

        // Back-to-back branches: last target wins
        go(1'b1, 8'h10, 1'b1);
        go(1'b1, 8'h20, 1'b1);
        for (int k = 1; k <= LAT + 1; k++) begin
            go(1'b0, 8'h00, 1'b1);
            if (k <= LAT) chk("b2b_gap", oValid, 1'b0);
            else chk_head("b2b", 8'h21);
        end

        // Simultaneous push and pop near full, then fill and drain in order
        pulse_clr("clr_pp");
        rel(1'b0);
        repeat (3) go(1'b0, 8'h00, 1'b0);
        go(1'b0, 8'h00, 1'b1);
        chk_head("pp_pop", 8'h01);
        repeat (4) go(1'b0, 8'h00, 1'b0);
        chk("pp_full_req", oImemReq, 1'b0);
        for (int j = 0; j < 4; j++) begin
            go(1'b0, 8'h00, 1'b1);
            chk_head("pp_order", 8'(j + 2));
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
